// File: rtl/ysyx_22040759_if_axi_rd.sv
// Instruction-fetch AXI4 read master: one outstanding single-beat 64-bit read per fetch.
// Optional one-entry line buffer enabled by defining YSYX_22040759_IF_LINEBUF_EN.
module ysyx_22040759_if_axi_rd #(
  parameter int AXI_ID_W  = 4,
  parameter int AXI_IF_ID = 0
) (
  input  logic                clk,
  input  logic                rst,
  // IF stage side
  input  logic                if_valid,
  input  logic [31:0]         inst_addr,
  output logic                if_ready,
  output logic [63:0]         if_data_read,
  output logic                if_err,
  // AXI4 read-address channel
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [31:0]         ar_addr,
  output logic [AXI_ID_W-1:0] ar_id,
  output logic [7:0]          ar_len,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  // AXI4 read-data channel
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [63:0]         r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_last,
  input  logic [AXI_ID_W-1:0] r_id,
  // FSM state for checkers
  output logic [1:0]          o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // ar_valid/r_ready/if_ready are pure decodes of the state register; if_valid while in
  // RESP acknowledges the returned instruction.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_word;
  logic        r_err;

  logic        w_r_done;
  logic        w_rsp_err;
  logic [31:0] w_r_word;
  logic        w_hit;
  logic [31:0] w_buf_word;
  logic        w_take_hit;
  logic        w_unused;

  assign w_r_done   = (r_state == S_R) && r_valid;
  assign w_rsp_err  = (r_resp != 2'b00);
  assign w_r_word   = r_addr[2] ? r_data[63:32] : r_data[31:0];
  assign w_take_hit = (r_state == S_IDLE) && if_valid && w_hit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (if_valid) w_next = w_hit ? S_RESP : S_AR;
      S_AR:   if (ar_ready) w_next = S_R;
      S_R:    if (r_valid)  w_next = S_RESP;
      S_RESP: if (if_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= 32'h0;
      r_word  <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && if_valid) r_addr <= inst_addr;
      if (w_r_done) begin
        // An error response hands the pipeline a NOP so nothing bogus executes.
        r_word <= w_rsp_err ? NOP_INST : w_r_word;
        r_err  <= w_rsp_err;
      end else if (w_take_hit) begin
        r_word <= w_buf_word;
        r_err  <= 1'b0;
      end
    end
  end

`ifdef YSYX_22040759_IF_LINEBUF_EN
  logic        r_buf_valid;
  logic [28:0] r_buf_tag;
  logic [63:0] r_buf_data;

  // Only clean responses are cached, so an errored line is always refetched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= 29'h0;
      r_buf_data  <= 64'h0;
    end else if (w_r_done && !w_rsp_err) begin
      r_buf_valid <= 1'b1;
      r_buf_tag   <= r_addr[31:3];
      r_buf_data  <= r_data;
    end
  end

  assign w_hit      = r_buf_valid && (r_buf_tag == inst_addr[31:3]);
  assign w_buf_word = inst_addr[2] ? r_buf_data[63:32] : r_buf_data[31:0];
`else
  assign w_hit      = 1'b0;
  assign w_buf_word = 32'h0;
`endif

  assign ar_valid     = (r_state == S_AR);
  assign ar_addr      = {r_addr[31:3], 3'b000};
  assign ar_id        = AXI_ID_W'(AXI_IF_ID);
  assign ar_len       = 8'd0;
  assign ar_size      = 3'b011;
  assign ar_burst     = 2'b01;
  assign r_ready      = (r_state == S_R);
  assign if_ready     = (r_state == S_RESP);
  assign if_err       = if_ready && r_err;
  assign if_data_read = {32'h0, r_word};
  assign o_dbg_state  = r_state;

  // Single-beat reads from a single ID: r_last and r_id carry no information here.
  assign w_unused = ^{r_last, r_id, r_addr[1:0]};

endmodule

// File: tb/tb_ysyx_22040759_if_axi_rd.sv
// Bench for ysyx_22040759_if_axi_rd: directed vector table, reset corner cases and
// randomized fetches against a line-level memory/buffer model; honours YSYX_22040759_IF_LINEBUF_EN.
module tb_ysyx_22040759_if_axi_rd;

`ifdef YSYX_22040759_IF_LINEBUF_EN
  localparam bit LB_EN = 1'b1;
`else
  localparam bit LB_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    int          ar_wait;
    int          r_delay;
    bit          err;
    int          hold;
    logic [31:0] exp_word;
    bit          exp_err;
    int          exp_lat;
    int          exp_ar;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_valid;
  logic [31:0] inst_addr;
  logic        if_ready;
  logic [63:0] if_data_read;
  logic        if_err;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;
  logic [1:0]  dbg_state;

  ysyx_22040759_if_axi_rd #(.AXI_ID_W(4), .AXI_IF_ID(0)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .inst_addr(inst_addr), .if_ready(if_ready),
    .if_data_read(if_data_read), .if_err(if_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id),
    .o_dbg_state(dbg_state)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  // slave model state
  int          ar_wait_left = 0;
  int          cfg_delay    = 0;
  bit          cfg_err      = 0;
  int          s_delay      = 0;
  bit          s_busy       = 0;
  logic [31:0] s_addr       = 32'h0;
  int          ar_hs_cnt    = 0;

  // reference model: one cached line
  bit          m_buf_valid = 0;
  logic [28:0] m_buf_tag   = 29'h0;

  function automatic logic [63:0] mem_line(input logic [31:0] a);
    logic [31:0] line;
    line = {a[31:3], 3'b000};
    if (line == 32'h8000_0000) return 64'h00000097_00000413;
    return {line + 32'h1111_0004, line ^ 32'h5A5A_0000};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [63:0] l;
    l = mem_line(a);
    return a[2] ? l[63:32] : l[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: handshakes are judged from the values stable before the edge,
  // then the slave drives its next-cycle outputs 1 time unit after the edge.
  task automatic tick();
    bit          pend_ar, pend_stall, pend_r;
    logic [31:0] pend_addr;
    pend_ar    = ar_valid && ar_ready;
    pend_stall = ar_valid && !ar_ready;
    pend_r     = r_valid && r_ready;
    pend_addr  = ar_addr;
    @(posedge clk);
    #1;
    if (pend_stall && ar_wait_left > 0) ar_wait_left--;
    if (pend_ar) begin
      ar_hs_cnt++;
      s_busy  = 1;
      s_addr  = pend_addr;
      s_delay = cfg_delay;
    end
    if (pend_r) begin
      s_busy  = 0;
      r_valid = 1'b0;
    end
    ar_ready = (ar_wait_left == 0);
    if (s_busy && !r_valid) begin
      if (s_delay == 0) begin
        r_valid = 1'b1;
        r_data  = mem_line(s_addr);
        r_resp  = cfg_err ? 2'b10 : 2'b00;
        r_last  = 1'b1;
        r_id    = 4'($urandom_range(0, 15));
      end else s_delay--;
    end
    if (!r_valid) r_data = {$urandom, $urandom};
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    if_valid = 1'b0;
    s_busy = 0; r_valid = 1'b0; ar_wait_left = 0;
    m_buf_valid = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic do_req(input vec_t v);
    int          n;
    bit          seen;
    int          hs0;
    logic [31:0] line;
    logic [63:0] exp_data;
    line = {v.addr[31:3], 3'b000};
    exp_q.push_back({32'h0, v.exp_word});
    hs0 = ar_hs_cnt;
    ar_wait_left = v.ar_wait; cfg_delay = v.r_delay; cfg_err = v.err;
    ar_ready = (v.ar_wait == 0);
    if_valid = 1'b1; inst_addr = v.addr;
    n = 0; seen = 0;
    while (!seen && n < v.exp_lat + 20) begin
      tick(); n++;
      if (if_ready) seen = 1;
      else begin
        if (ar_valid) begin
          chk("ar_addr", ar_addr, line);
          chk("ar_fields", {ar_len, ar_size, ar_burst, ar_id}, {8'd0, 3'b011, 2'b01, 4'd0});
        end
        // IF stage noise while a transaction is in flight must be ignored
        if_valid = 1'($urandom_range(0, 1)); inst_addr = $urandom;
      end
    end
    chk("resp_seen", seen, 1);
    if (!seen) begin
      void'(exp_q.pop_front());
      apply_reset();
      return;
    end
    exp_data = exp_q.pop_front();
    chk("latency", n, v.exp_lat);
    chk("if_data_read", if_data_read, exp_data);
    chk("if_err", if_err, v.exp_err);
    chk("ar_count", ar_hs_cnt - hs0, v.exp_ar);
    chk("ar_valid_in_resp", ar_valid, 0);
    for (int h = 0; h < v.hold; h++) begin
      if_valid = 1'b0; inst_addr = $urandom;
      tick();
      chk("hold_ready", if_ready, 1);
      chk("hold_data", if_data_read, exp_data);
    end
    if_valid = 1'b1;
    tick();
    chk("exit_resp", if_ready, 0);
    if_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input int w, input int d, input bit e,
                              input int h, input logic [31:0] ew, input bit ee,
                              input int el, input int ea);
    vec_t v;
    v.addr = a; v.ar_wait = w; v.r_delay = d; v.err = e; v.hold = h;
    v.exp_word = ew; v.exp_err = ee; v.exp_lat = el; v.exp_ar = ea;
    return v;
  endfunction

  function automatic vec_t gen_vec();
    vec_t v;
    bit   hit;
    v.addr    = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 3) | (32'($urandom_range(0, 1)) << 2);
    v.ar_wait = $urandom_range(0, 3);
    v.r_delay = $urandom_range(0, 3);
    v.err     = ($urandom_range(0, 7) == 0);
    v.hold    = $urandom_range(0, 2);
    hit = LB_EN && m_buf_valid && (m_buf_tag == v.addr[31:3]);
    if (hit) begin
      v.exp_word = mem_word(v.addr); v.exp_err = 0; v.exp_lat = 1; v.exp_ar = 0;
    end else begin
      v.exp_lat = 3 + v.ar_wait + v.r_delay; v.exp_ar = 1;
      if (v.err) begin
        v.exp_word = 32'h0000_0013; v.exp_err = 1;
      end else begin
        v.exp_word = mem_word(v.addr); v.exp_err = 0;
        m_buf_valid = 1; m_buf_tag = v.addr[31:3];
      end
    end
    return v;
  endfunction

  vec_t dir_tbl[12];
  vec_t rnd_tbl[$];

  initial begin
    int n;
    dir_tbl[0]  = mk(32'h8000_0000, 0, 0, 0, 0, 32'h0000_0413, 0, 3, 1);
    dir_tbl[1]  = mk(32'h8000_1000, 0, 0, 0, 0, 32'hDA5A_1000, 0, 3, 1);
    dir_tbl[2]  = mk(32'h8000_0004, 0, 0, 0, 0, 32'h0000_0097, 0, 3, 1);
    dir_tbl[3]  = mk(32'h8000_0000, 0, 0, 0, 0, 32'h0000_0413, 0, LB_EN ? 1 : 3, LB_EN ? 0 : 1);
    dir_tbl[4]  = mk(32'h8000_0100, 5, 0, 0, 0, 32'hDA5A_0100, 0, 8, 1);
    dir_tbl[5]  = mk(32'h8000_0200, 0, 0, 1, 0, 32'h0000_0013, 1, 3, 1);
    dir_tbl[6]  = mk(32'h8000_0200, 0, 0, 0, 0, 32'hDA5A_0200, 0, 3, 1);
    dir_tbl[7]  = mk(32'h8000_0208, 0, 0, 0, 3, 32'hDA5A_0208, 0, 3, 1);
    dir_tbl[8]  = mk(32'h8000_020C, 0, 0, 0, 0, 32'h9111_020C, 0, LB_EN ? 1 : 3, LB_EN ? 0 : 1);
    dir_tbl[9]  = mk(32'h8000_0208, 0, 4, 0, 0, 32'hDA5A_0208, 0, LB_EN ? 1 : 7, LB_EN ? 0 : 1);
    dir_tbl[10] = mk(32'h8000_0010, 2, 3, 0, 1, 32'hDA5A_0010, 0, 8, 1);
    dir_tbl[11] = mk(32'h8000_0014, 1, 1, 1, 0, LB_EN ? 32'h9111_0014 : 32'h0000_0013,
                     LB_EN ? 0 : 1, LB_EN ? 1 : 5, LB_EN ? 0 : 1);

    rst = 1'b1; if_valid = 1'b0; inst_addr = 32'h0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = 64'h0; r_resp = 2'b00; r_last = 1'b0; r_id = 4'h0;
    #2 rst = 1'b0;
    #2;
    chk("rst_if_ready", if_ready, 0);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_if_err", if_err, 0);
    chk("rst_if_data_read", if_data_read, 0);
    chk("rst_ar_addr", ar_addr, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) do_req(dir_tbl[i]);

    // reset while waiting in R: outputs drop without a clock edge
    if_valid = 1'b1; inst_addr = 32'h8000_0300;
    ar_wait_left = 0; ar_ready = 1'b1; cfg_delay = 6; cfg_err = 0;
    tick();
    if_valid = 1'b0;
    n = 0;
    while (!r_ready && n < 10) begin tick(); n++; end
    chk("r_ready_before_rst", r_ready, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_r_ready", r_ready, 0);
    chk("async_rst_if_ready", if_ready, 0);
    chk("async_rst_ar_valid", ar_valid, 0);
    chk("async_rst_ar_addr", ar_addr, 0);
    s_busy = 0; r_valid = 1'b0; m_buf_valid = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ar_valid", ar_valid, 0);
    chk("post_rst_r_ready", r_ready, 0);
    chk("post_rst_if_ready", if_ready, 0);
    do_req(mk(32'h8000_0000, 0, 0, 0, 0, 32'h0000_0413, 0, 3, 1));

    // reset while presenting an error response
    if_valid = 1'b1; inst_addr = 32'h8000_0404;
    ar_wait_left = 0; ar_ready = 1'b1; cfg_delay = 0; cfg_err = 1;
    tick();
    if_valid = 1'b0;
    n = 0;
    while (!if_ready && n < 10) begin tick(); n++; end
    chk("err_resp_if_err", if_err, 1);
    chk("err_resp_data", if_data_read, 64'h13);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_err", if_err, 0);
    chk("async_rst_data", if_data_read, 0);
    chk("async_rst_resp_ready", if_ready, 0);
    s_busy = 0; r_valid = 1'b0; m_buf_valid = 0;
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 40; i++) rnd_tbl.push_back(gen_vec());
    foreach (rnd_tbl[i]) do_req(rnd_tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
